apb_timer_irq_ctrl: RTL
=======================

Name: apb_timer_irq_ctrl

Overview:
- Interrupt collector that sits directly downstream of the APB timer units.
- Captures rising edges of up to NUM_IRQ timer IRQ lines (irq_lo_o/irq_hi_o of several timers) into pending bits.
- Masks pending bits under APB control, priority-encodes them, and presents one request at a time to the core through a req/ack handshake.
- Software can read, set and clear pending and mask state over APB.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width; only PADDR[4:0] is decoded.
- NUM_IRQ, 8, number of IRQ inputs; legal range 1..32.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- irq_i  in  NUM_IRQ  timer IRQ lines, HCLK-synchronous, level.
- core_irq_req_o  out  1  request to core.
- core_irq_id_o  out  5  index of the requested IRQ.
- core_irq_ack_i  in  1  single-cycle acknowledge from core.
- core_irq_ack_id_i  in  5  index being acknowledged.

Behaviour:
- Clock and reset (already decided): reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset values: all registers 0, FSM in IDLE, core_irq_req_o=0, core_irq_id_o=0, PRDATA=0.

APB interface:
- PREADY=PSEL&PENABLE; no wait states. PSLVERR=0.
- Writes take effect at the edge that ends the access phase.
- PRDATA is 0 outside read access phases and for unmapped addresses. Writes to unmapped addresses are ignored.
- Register map:
  - 0x00 MASK: RW.
  - 0x04 MASK_SET: W, MASK |= PWDATA.
  - 0x08 MASK_CLR: W, MASK &= ~PWDATA.
  - 0x0C PENDING: RO.
  - 0x10 PENDING_SET: W.
  - 0x14 PENDING_CLR: W.
  - 0x18 STATUS: RO, [0]=core_irq_req_o, [12:8]=core_irq_id_o.
- Bits at or above NUM_IRQ read 0 and ignore writes. Write-only registers read 0.

Edge capture:
- irq_q registers irq_i each cycle.
- edge = irq_i & ~irq_q.
- pending_next = (pending & ~clr_mask) | edge | set_mask.
  - clr_mask = PENDING_CLR write data, OR the one-hot bit of an accepted ack.
  - Set always wins over clear in the same cycle, so a new edge is never lost.
- A level held high produces exactly one pending set. It must go low for at least 1 cycle to re-arm.

Arbitration:
- active = pending & MASK.
- The winner is the lowest set index (combinational priority encoder).

Request FSM:
- IDLE: if |active, latch winner into id_q and go to REQ.
- REQ: core_irq_req_o=1, core_irq_id_o=id_q, held stable.
  - If core_irq_ack_i is high and core_irq_ack_id_i==id_q: clear pending[id_q], go to GAP.
  - Else if active[id_q]==0 (software cleared the pending or mask bit): drop the request, go to IDLE with no ack required.
  - A higher-priority IRQ arriving in REQ does not pre-empt the current request.
- GAP: req=0 for exactly 1 cycle, then IDLE.
- Acks outside REQ, or with a mismatched id, are ignored and have no side effect.

Timing and outputs:
- core_irq_req_o and core_irq_id_o are registered from the FSM.
- core_irq_id_o keeps its last value when req is low.
- Latency: irq_i rising sampled at edge k → pending visible after k → req high after edge k+1.
- Minimum ack-to-next-request spacing is 2 cycles (the GAP cycle).

Reset mid-operation: asynchronous clear of everything, including irq_q. An irq_i held high through reset therefore produces one edge after reset release.

Test Plan:
- MASK=0x01; irq_i[0] pulses at cycle 10 → PENDING=0x01 after edge 10; req=1, id=0 after edge 11; ack id 0 → PENDING=0, req low for 1 cycle then stays low.
- MASK=0xFF; irq_i[5] and irq_i[2] rise together → id=2 first. After ack, GAP, then id=5. Acking with id 5 during the first request is ignored.
- irq_i[3] held high for 50 cycles with MASK bit 3 set → exactly one request. Drop for 1 cycle and re-raise → second request.
- During REQ for id 1, write PENDING_CLR=0x02 → req drops next cycle, FSM in IDLE, no ack needed. Repeat using MASK_CLR=0x02 → same result.
- In one cycle, an irq_i[4] rising edge coincides with a PENDING_CLR=0x10 write → PENDING[4]=1 (set wins).
- Reads at 0x1C/0x04 return 0. A write to MASK of 0xFFFFFFFF with NUM_IRQ=8 reads back 0x000000FF. Asserting HRESETn low during REQ → req=0 and all registers 0 immediately.

Source files
------------

// File: rtl/apb_timer_irq_ctrl.sv
// Interrupt collector for the APB timer IRQ lines: edge capture, masking,
// lowest-index priority and a single outstanding req/ack request to the core.
module apb_timer_irq_ctrl #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_IRQ        = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_IRQ-1:0]        irq_i,
  output logic                      core_irq_req_o,
  output logic [4:0]                core_irq_id_o,
  input  logic                      core_irq_ack_i,
  input  logic [4:0]                core_irq_ack_id_i
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] ADDR_MASK     = 5'h00;
  localparam logic [4:0] ADDR_MASK_SET = 5'h04;
  localparam logic [4:0] ADDR_MASK_CLR = 5'h08;
  localparam logic [4:0] ADDR_PEND     = 5'h0C;
  localparam logic [4:0] ADDR_PEND_SET = 5'h10;
  localparam logic [4:0] ADDR_PEND_CLR = 5'h14;
  localparam logic [4:0] ADDR_STATUS   = 5'h18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [NUM_IRQ-1:0]  irq_edge;
  logic [NUM_IRQ-1:0]  set_bits, clr_bits, ack_onehot;
  logic [NUM_IRQ-1:0]  active;
  logic [DATA_W-1:0]   active_ext;
  logic [ID_W-1:0]     win_id;
  logic [NUM_IRQ-1:0]  wdata;
  logic [4:0]          addr;
  logic                access, wr, rd, ack_hit;
  logic [DATA_W-1:0]   rdata;
  logic                unused_bits;

  // APB decode; only the low five address bits select a register
  assign access  = PSEL & PENABLE;
  assign wr      = access & PWRITE;
  assign rd      = access & ~PWRITE;
  assign addr    = PADDR[4:0];
  assign wdata   = PWDATA[NUM_IRQ-1:0];
  assign PREADY  = access;
  assign PSLVERR = 1'b0;
  assign PRDATA  = rd ? rdata : '0;

  assign unused_bits = ^{PADDR, PWDATA};

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_MASK:   rdata = DATA_W'(mask_q);
      ADDR_PEND:   rdata = DATA_W'(pending_q);
      ADDR_STATUS: rdata = {19'd0, id_q, 7'd0, req_q};
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    if (wr) begin
      case (addr)
        ADDR_MASK:     mask_d = wdata;
        ADDR_MASK_SET: mask_d = mask_q | wdata;
        ADDR_MASK_CLR: mask_d = mask_q & ~wdata;
        default:       mask_d = mask_q;
      endcase
    end
  end

  // Sets (edges and software) are applied after clears so a new edge is never lost
  assign irq_edge   = irq_i & ~irq_q;
  assign ack_hit    = (state_q == REQ) && core_irq_ack_i && (core_irq_ack_id_i == id_q);
  assign ack_onehot = NUM_IRQ'(32'd1 << id_q);
  assign set_bits   = (wr && addr == ADDR_PEND_SET) ? wdata : '0;
  assign clr_bits   = ((wr && addr == ADDR_PEND_CLR) ? wdata : '0) |
                      (ack_hit ? ack_onehot : '0);
  assign pending_d  = (pending_q & ~clr_bits) | irq_edge | set_bits;

  assign active     = pending_q & mask_q;
  assign active_ext = DATA_W'(active);

  // Lowest set index wins
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = win_id;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (ack_hit) begin
          state_d = GAP;
          req_d   = 1'b0;
        end else if (!active_ext[id_q]) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      id_q      <= '0;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      irq_q     <= irq_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign core_irq_req_o = req_q;
  assign core_irq_id_o  = id_q;

endmodule
